// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop sync, debounce and press/release pulses.
// Define BTN_AUTOREPEAT_EN for hold-to-repeat on btn_press.
module button_conditioner #(
  parameter int N_BTN = 4,
  parameter int DEBOUNCE_CYCLES = 512,
  parameter int REPEAT_DELAY = 5_000_000,
  parameter int REPEAT_RATE = 2_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(4'b1100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] flip;
  logic [N_BTN-1:0] rep_hit;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [CW-1:0] cnt;

    assign flip[i] = (s2[i] != btn_level[i]) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (s2[i] == btn_level[i] || flip[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  for (genvar i = 0; i < N_BTN; i++) begin : g_rep
    if (REPEAT_MASK[i]) begin : g_on
      logic [23:0] rcnt;
      logic        phase;
      logic [23:0] limit;

      // phase 0 waits the initial delay, phase 1 paces the repeats
      assign limit = phase ? 24'(REPEAT_RATE - 1)
                           : 24'(REPEAT_DELAY - 1);
      assign rep_hit[i] = btn_level[i] & ~flip[i] & (rcnt == limit);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rcnt  <= '0;
          phase <= 1'b0;
        end else if (!btn_level[i] || flip[i]) begin
          rcnt  <= '0;
          phase <= 1'b0;
        end else if (rep_hit[i]) begin
          rcnt  <= '0;
          phase <= 1'b1;
        end else begin
          rcnt  <= rcnt + 24'd1;
        end
      end
    end else begin : g_off
      assign rep_hit[i] = 1'b0;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_RATE[0]};
  assign rep_hit = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1          <= '0;
      s2          <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      s1          <= btn_raw;
      s2          <= s1;
      btn_level   <= btn_level ^ flip;
      btn_press   <= (flip & ~btn_level) | rep_hit;
      btn_release <= flip & btn_level;
    end
  end

endmodule
